divisor_relojes_param: RTL

Parametrised clock-divider block generating `N_CH` phase-aligned divided clocks from the `clk32f` master clock. It is the successor to the fixed three-output divider (÷8, ÷16, ÷32). Each channel's ratio is selectable at run time as a power of two. Ratio changes take effect only at a common alignment point, so no output glitches. Each channel also emits a one-cycle rising-edge tick for logic that stays in the `clk32f` domain. The block sits at the top of the clocking tree and feeds the serialiser/deserialiser stages and their probador.

---
 rtl/divisor_relojes_param_pkg.sv | 8 +
 rtl/divisor_relojes_param_canal.sv | 53 +++++
 rtl/divisor_relojes_param.sv | 68 ++++++
 3 files changed

// File: rtl/divisor_relojes_param_pkg.sv
// Shared defaults for the parametrised clock divider: counter/select widths
// and the reset-time per-channel select (ch0 /8, ch1 /16, ch2 /32).
package divisor_relojes_param_pkg;
    localparam int N_CH_DEF  = 3;
    localparam int CNT_W_DEF = 5;
    localparam int SEL_W_DEF = 3;
    localparam logic [N_CH_DEF*SEL_W_DEF-1:0] DEF_SEL_DEF = {3'd4, 3'd3, 3'd2};
endpackage

// File: rtl/divisor_relojes_param_canal.sv
// One divided-clock channel: pending/active select pair with clamp, bit mux
// on the shared counter and a registered rising-edge tick.
module canal_reloj #(
    parameter int                 CNT_W = 5,
    parameter int                 SEL_W = 3,
    parameter logic [SEL_W-1:0]   DEF   = '0
) (
    input  logic             clk32f,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wrap_i,
    input  logic             sel_we_i,
    input  logic [SEL_W-1:0] div_sel_i,
    input  logic [CNT_W-1:0] cnt_nxt_i,
    output logic             clk_o,
    output logic             tick_o
);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(CNT_W - 1);

    logic [SEL_W-1:0] act_q, act_d, pend_q, pend_d, sel_cl;
    logic [CNT_W-1:0] cnt_sh;
    logic             lvl, clk_q, clk_d, tick_q, tick_d;

    always_comb begin
        sel_cl = (div_sel_i > SEL_MAX) ? SEL_MAX : div_sel_i;
        pend_d = sel_we_i ? sel_cl : pend_q;
        act_d  = act_q;
        // A write landing on the wrap cycle bypasses the pending register
        if (wrap_i)
            act_d = sel_we_i ? sel_cl : pend_q;
        cnt_sh = cnt_nxt_i >> act_d;
        lvl    = cnt_sh[0];
        clk_d  = en_i ? lvl : clk_q;
        tick_d = en_i & lvl & ~clk_q;
    end

    always_ff @(posedge clk32f) begin
        if (rst) begin
            act_q  <= DEF;
            pend_q <= DEF;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
endmodule

// File: rtl/divisor_relojes_param.sv
// Parametrised power-of-two clock divider: one shared free-running counter,
// N_CH channels whose ratio changes are applied only at the counter wrap.
module divisor_relojes_param
    import divisor_relojes_param_pkg::*;
#(
    parameter int                        N_CH    = N_CH_DEF,
    parameter int                        CNT_W   = CNT_W_DEF,
    parameter int                        SEL_W   = SEL_W_DEF,
    parameter logic [N_CH*SEL_W-1:0]     DEF_SEL = DEF_SEL_DEF
) (
    input  logic                  clk32f,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sel_we,
    input  logic [N_CH*SEL_W-1:0] div_sel,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick,
    output logic                  sel_pend,
    output logic                  locked
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             sel_pend_q, sel_pend_d, locked_q, locked_d;

    always_comb begin
        cnt_d      = en ? cnt_q + CNT_W'(1) : cnt_q;
        wrap       = en & (&cnt_q);
        sel_pend_d = sel_pend_q;
        if (wrap)
            sel_pend_d = 1'b0;
        else if (sel_we)
            sel_pend_d = 1'b1;
        locked_d   = locked_q | wrap;
    end

    always_ff @(posedge clk32f) begin
        if (rst) begin
            cnt_q      <= '0;
            sel_pend_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sel_pend_q <= sel_pend_d;
            locked_q   <= locked_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        canal_reloj #(
            .CNT_W (CNT_W),
            .SEL_W (SEL_W),
            .DEF   (DEF_SEL[i*SEL_W +: SEL_W])
        ) u_ch (
            .clk32f    (clk32f),
            .rst       (rst),
            .en_i      (en),
            .wrap_i    (wrap),
            .sel_we_i  (sel_we),
            .div_sel_i (div_sel[i*SEL_W +: SEL_W]),
            .cnt_nxt_i (cnt_d),
            .clk_o     (clk_out[i]),
            .tick_o    (tick[i])
        );
    end

    assign sel_pend = sel_pend_q;
    assign locked   = locked_q;
endmodule
